// File: rtl/riscv_corereorderbuffer_if.sv
// Bundle of the ROB's allocate, writeback, commit and operand-lookup signals.
// The master side is the issue/execute pipeline; the slave side is the ROB itself.
interface riscv_corereorderbuffer_if #(
  parameter int IDX_W = 4
);
  logic             alloc0_val;
  logic             alloc0_dst_en;
  logic [4:0]       alloc0_dst;
  logic             alloc1_val;
  logic             alloc1_dst_en;
  logic [4:0]       alloc1_dst;
  logic [IDX_W-1:0] alloc0_slot;
  logic [IDX_W-1:0] alloc1_slot;
  logic             alloc_rdy;
  logic             wbA_val;
  logic [IDX_W-1:0] wbA_slot;
  logic [31:0]      wbA_data;
  logic             wbB_val;
  logic [IDX_W-1:0] wbB_slot;
  logic [31:0]      wbB_data;
  logic             commit0_val;
  logic             commit0_wen;
  logic [4:0]       commit0_dst;
  logic [31:0]      commit0_data;
  logic             commit1_val;
  logic             commit1_wen;
  logic [4:0]       commit1_dst;
  logic [31:0]      commit1_data;
  logic [19:0]      lkp_reg;
  logic [3:0]       lkp_hit;
  logic [127:0]     lkp_data;

  modport master (
    output alloc0_val, alloc0_dst_en, alloc0_dst,
    output alloc1_val, alloc1_dst_en, alloc1_dst,
    input  alloc0_slot, alloc1_slot, alloc_rdy,
    output wbA_val, wbA_slot, wbA_data,
    output wbB_val, wbB_slot, wbB_data,
    input  commit0_val, commit0_wen, commit0_dst, commit0_data,
    input  commit1_val, commit1_wen, commit1_dst, commit1_data,
    output lkp_reg,
    input  lkp_hit, lkp_data
  );

  modport slave (
    input  alloc0_val, alloc0_dst_en, alloc0_dst,
    input  alloc1_val, alloc1_dst_en, alloc1_dst,
    output alloc0_slot, alloc1_slot, alloc_rdy,
    input  wbA_val, wbA_slot, wbA_data,
    input  wbB_val, wbB_slot, wbB_data,
    output commit0_val, commit0_wen, commit0_dst, commit0_data,
    output commit1_val, commit1_wen, commit1_dst, commit1_data,
    input  lkp_reg,
    output lkp_hit, lkp_data
  );
endinterface

// File: rtl/riscv_corereorderbuffer.sv
// 2-wide in-order-commit reorder buffer: in-order allocation, out-of-order
// writeback from pipes A/B, up to two retirements per cycle, and operand bypass.
module riscv_corereorderbuffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic                          clk,
  input logic                          reset,
  riscv_corereorderbuffer_if.slave     rob
);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  localparam cnt_t ENTRIES_C = cnt_t'(ENTRIES);

  logic [ENTRIES-1:0] valid_r;
  logic [ENTRIES-1:0] done_r;
  logic [ENTRIES-1:0] dst_en_r;
  logic [4:0]         dst_r  [ENTRIES];
  logic [31:0]        data_r [ENTRIES];
  idx_t               head_r;
  idx_t               tail_r;
  cnt_t               count_r;

  idx_t head1_s;
  idx_t tail1_s;
  cnt_t free_s;
  logic alloc_rdy_s;
  logic alloc0_ok_s;
  logic alloc1_ok_s;
  logic commit0_s;
  logic commit1_s;
  cnt_t n_alloc_s;
  cnt_t n_commit_s;

  // Free-space, allocation-accept and in-order commit decisions from registered state.
  always_comb begin
    head1_s     = head_r + idx_t'(1);
    tail1_s     = tail_r + idx_t'(1);
    free_s      = ENTRIES_C - count_r;
    alloc_rdy_s = (free_s >= cnt_t'(2));
    // An allocation without room, or ir1 without ir0, leaves state untouched.
    alloc0_ok_s = rob.alloc0_val & alloc_rdy_s;
    alloc1_ok_s = alloc0_ok_s & rob.alloc1_val;
    commit0_s   = valid_r[head_r] & done_r[head_r];
    commit1_s   = commit0_s & valid_r[head1_s] & done_r[head1_s];
    n_alloc_s   = cnt_t'(alloc0_ok_s) + cnt_t'(alloc1_ok_s);
    n_commit_s  = cnt_t'(commit0_s) + cnt_t'(commit1_s);
  end

  assign rob.alloc_rdy    = alloc_rdy_s;
  assign rob.alloc0_slot  = tail_r;
  assign rob.alloc1_slot  = tail1_s;
  assign rob.commit0_val  = commit0_s;
  assign rob.commit0_wen  = commit0_s & dst_en_r[head_r] & (dst_r[head_r] != 5'd0);
  assign rob.commit0_dst  = dst_r[head_r];
  assign rob.commit0_data = data_r[head_r];
  assign rob.commit1_val  = commit1_s;
  assign rob.commit1_wen  = commit1_s & dst_en_r[head1_s] & (dst_r[head1_s] != 5'd0);
  assign rob.commit1_dst  = dst_r[head1_s];
  assign rob.commit1_data = data_r[head1_s];

  // Entry array and pointer update: retire at head, allocate at tail, fill on writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r  <= '0;
      done_r   <= '0;
      dst_en_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        dst_r[i]  <= 5'd0;
        data_r[i] <= 32'd0;
      end
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
    end else begin
      if (commit0_s) begin
        valid_r[head_r] <= 1'b0;
        done_r[head_r]  <= 1'b0;
      end
      if (commit1_s) begin
        valid_r[head1_s] <= 1'b0;
        done_r[head1_s]  <= 1'b0;
      end
      if (alloc0_ok_s) begin
        valid_r[tail_r]  <= 1'b1;
        done_r[tail_r]   <= 1'b0;
        dst_en_r[tail_r] <= rob.alloc0_dst_en;
        dst_r[tail_r]    <= rob.alloc0_dst;
      end
      if (alloc1_ok_s) begin
        valid_r[tail1_s]  <= 1'b1;
        done_r[tail1_s]   <= 1'b0;
        dst_en_r[tail1_s] <= rob.alloc1_dst_en;
        dst_r[tail1_s]    <= rob.alloc1_dst;
      end
      // Writebacks only land on live entries; freshly allocated slots are not yet valid.
      if (rob.wbA_val && valid_r[rob.wbA_slot]) begin
        done_r[rob.wbA_slot] <= 1'b1;
        data_r[rob.wbA_slot] <= rob.wbA_data;
      end
      if (rob.wbB_val && valid_r[rob.wbB_slot]) begin
        done_r[rob.wbB_slot] <= 1'b1;
        data_r[rob.wbB_slot] <= rob.wbB_data;
      end
      head_r  <= head_r + n_commit_s[IDX_W-1:0];
      tail_r  <= tail_r + n_alloc_s[IDX_W-1:0];
      count_r <= count_r + n_alloc_s - n_commit_s;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lkp
    logic [4:0]  reg_s;
    logic        found_s;
    logic        found_done_s;
    logic [31:0] found_data_s;
    logic        hit_s;
    idx_t        idx_s;

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
      reg_s        = rob.lkp_reg[5*k +: 5];
      found_s      = 1'b0;
      found_done_s = 1'b0;
      found_data_s = 32'd0;
      idx_s        = head_r;
      for (int i = 0; i < ENTRIES; i++) begin
        idx_s = head_r + idx_t'(i);
        if (valid_r[idx_s] && dst_en_r[idx_s] && (dst_r[idx_s] == reg_s)) begin
          found_s      = 1'b1;
          found_done_s = done_r[idx_s];
          found_data_s = data_r[idx_s];
        end else begin
          found_s      = found_s;
        end
      end
      hit_s = found_s & found_done_s & (reg_s != 5'd0);
    end

    assign rob.lkp_hit[k]          = hit_s;
    assign rob.lkp_data[32*k +: 32] = hit_s ? found_data_s : 32'd0;
  end
endmodule

// File: tb/tb_riscv_corereorderbuffer.sv
// Directed bench for the reorder buffer: dual commit, full/wrap, bypass lookup,
// non-writing retirements, in-order hold and asynchronous reset.
module tb_riscv_corereorderbuffer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  riscv_corereorderbuffer_if #(.IDX_W(4)) rob_if ();

  riscv_corereorderbuffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol guard on the stimulus: ir1 may never allocate alone.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(rob_if.alloc1_val && !rob_if.alloc0_val))
        else $error("illegal alloc1_val without alloc0_val");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rob_if.alloc0_val = 1'b0;
    rob_if.alloc1_val = 1'b0;
    rob_if.wbA_val    = 1'b0;
    rob_if.wbB_val    = 1'b0;
  endtask

  task automatic set_alloc0(input logic en, input logic [4:0] d);
    rob_if.alloc0_val    = 1'b1;
    rob_if.alloc0_dst_en = en;
    rob_if.alloc0_dst    = d;
  endtask

  task automatic set_alloc1(input logic en, input logic [4:0] d);
    rob_if.alloc1_val    = 1'b1;
    rob_if.alloc1_dst_en = en;
    rob_if.alloc1_dst    = d;
  endtask

  task automatic set_wba(input logic [3:0] s, input logic [31:0] d);
    rob_if.wbA_val  = 1'b1;
    rob_if.wbA_slot = s;
    rob_if.wbA_data = d;
  endtask

  task automatic set_wbb(input logic [3:0] s, input logic [31:0] d);
    rob_if.wbB_val  = 1'b1;
    rob_if.wbB_slot = s;
    rob_if.wbB_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    rob_if.alloc0_val = 1'b0; rob_if.alloc0_dst_en = 1'b0; rob_if.alloc0_dst = 5'd0;
    rob_if.alloc1_val = 1'b0; rob_if.alloc1_dst_en = 1'b0; rob_if.alloc1_dst = 5'd0;
    rob_if.wbA_val = 1'b0; rob_if.wbA_slot = 4'd0; rob_if.wbA_data = 32'd0;
    rob_if.wbB_val = 1'b0; rob_if.wbB_slot = 4'd0; rob_if.wbB_data = 32'd0;
    rob_if.lkp_reg = 20'd0;
    #1;
    check("rst_alloc_rdy", 32'(rob_if.alloc_rdy), 32'd1);
    check("rst_slot0", 32'(rob_if.alloc0_slot), 32'd0);
    check("rst_slot1", 32'(rob_if.alloc1_slot), 32'd1);
    check("rst_commit0_val", 32'(rob_if.commit0_val), 32'd0);
    check("rst_lkp_hit", 32'(rob_if.lkp_hit), 32'd0);
    #12;
    reset = 1'b1;
    tick();

    // Dual allocate x5/x6, out-of-order writeback, dual commit.
    set_alloc0(1'b1, 5'd5);
    set_alloc1(1'b1, 5'd6);
    tick();
    check("pair_tail", 32'(rob_if.alloc0_slot), 32'd2);
    set_wbb(4'd1, 32'hBEEF);
    tick();
    check("pair_hold_c0", 32'(rob_if.commit0_val), 32'd0);
    set_wba(4'd0, 32'h1234);
    tick();
    check("pair_c0_val", 32'(rob_if.commit0_val), 32'd1);
    check("pair_c0_wen", 32'(rob_if.commit0_wen), 32'd1);
    check("pair_c0_dst", 32'(rob_if.commit0_dst), 32'd5);
    check("pair_c0_data", rob_if.commit0_data, 32'h1234);
    check("pair_c1_val", 32'(rob_if.commit1_val), 32'd1);
    check("pair_c1_wen", 32'(rob_if.commit1_wen), 32'd1);
    check("pair_c1_dst", 32'(rob_if.commit1_dst), 32'd6);
    check("pair_c1_data", rob_if.commit1_data, 32'hBEEF);
    rob_if.lkp_reg = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    check("pair_lkp_retiring", 32'(rob_if.lkp_hit), 32'd1);
    check("pair_lkp_data", rob_if.lkp_data[31:0], 32'h1234);
    tick();
    check("pair_after_c0", 32'(rob_if.commit0_val), 32'd0);
    check("pair_after_slot", 32'(rob_if.alloc0_slot), 32'd2);

    // Two x7 producers in slots 2/3: the younger one gates the bypass.
    check("lkp_slot0", 32'(rob_if.alloc0_slot), 32'd2);
    set_alloc0(1'b1, 5'd7);
    set_alloc1(1'b1, 5'd7);
    tick();
    set_wba(4'd2, 32'hBB);
    tick();
    rob_if.lkp_reg = {5'd7, 5'd0, 5'd7, 5'd0};
    #1;
    check("lkp_young_pending", 32'(rob_if.lkp_hit), 32'd0);
    check("lkp_c0_data", rob_if.commit0_data, 32'hBB);
    check("lkp_c1_hold", 32'(rob_if.commit1_val), 32'd0);
    set_wbb(4'd3, 32'hAA);
    tick();
    check("lkp_young_done", 32'(rob_if.lkp_hit), 32'hA);
    check("lkp_data_op1", rob_if.lkp_data[63:32], 32'hAA);
    check("lkp_data_op3", rob_if.lkp_data[127:96], 32'hAA);
    check("lkp_data_x0", rob_if.lkp_data[31:0], 32'd0);
    tick();

    // dst=0 and dst_en=0 entries retire without a register write; head-not-done holds both.
    set_alloc0(1'b1, 5'd0);
    set_alloc1(1'b0, 5'd9);
    tick();
    set_wbb(4'd5, 32'h55);
    tick();
    check("hold_c0_val", 32'(rob_if.commit0_val), 32'd0);
    check("hold_c1_val", 32'(rob_if.commit1_val), 32'd0);
    set_wba(4'd4, 32'h44);
    tick();
    check("nowr_c0_val", 32'(rob_if.commit0_val), 32'd1);
    check("nowr_c0_wen", 32'(rob_if.commit0_wen), 32'd0);
    check("nowr_c1_val", 32'(rob_if.commit1_val), 32'd1);
    check("nowr_c1_wen", 32'(rob_if.commit1_wen), 32'd0);
    check("nowr_c1_data", rob_if.commit1_data, 32'h55);
    tick();

    // Fill to 15 entries from slot 6 with no writebacks; tail wraps 15->0.
    for (int i = 0; i < 15; i++) begin
      set_alloc0(1'b1, 5'((i % 31) + 1));
      tick();
      if (i == 13) check("full_rdy_at14", 32'(rob_if.alloc_rdy), 32'd1);
    end
    check("full_rdy_at15", 32'(rob_if.alloc_rdy), 32'd0);
    check("full_tail", 32'(rob_if.alloc0_slot), 32'd5);
    set_alloc0(1'b1, 5'd30);
    tick();
    check("full_ignored_tail", 32'(rob_if.alloc0_slot), 32'd5);
    set_wba(4'd6, 32'h1006);
    tick();
    check("full_c0_val", 32'(rob_if.commit0_val), 32'd1);
    check("full_c0_dst", 32'(rob_if.commit0_dst), 32'd1);
    check("full_rdy_same_cycle", 32'(rob_if.alloc_rdy), 32'd0);
    tick();
    check("full_rdy_freed", 32'(rob_if.alloc_rdy), 32'd1);
    check("full_next_c0", 32'(rob_if.commit0_val), 32'd0);
    for (int j = 0; j < 10; j++) begin
      set_wba(4'((7 + j) % 16), 32'h1000 + 32'((7 + j) % 16));
      tick();
    end
    check("wrap_c0_val", 32'(rob_if.commit0_val), 32'd1);
    check("wrap_c0_dst", 32'(rob_if.commit0_dst), 32'd11);
    check("wrap_c0_data", rob_if.commit0_data, 32'h1000);
    check("wrap_c1_val", 32'(rob_if.commit1_val), 32'd0);
    tick();
    check("wrap_tail", 32'(rob_if.alloc0_slot), 32'd5);

    // Five live entries (slots 1..5), then an asynchronous reset mid-stream.
    set_alloc0(1'b1, 5'd20);
    tick();
    set_wba(4'd1, 32'h2001);
    tick();
    check("pre_rst_c0_val", 32'(rob_if.commit0_val), 32'd1);
    check("pre_rst_c0_dst", 32'(rob_if.commit0_dst), 32'd12);
    #2;
    reset = 1'b0;
    #1;
    check("arst_c0_val", 32'(rob_if.commit0_val), 32'd0);
    check("arst_alloc_rdy", 32'(rob_if.alloc_rdy), 32'd1);
    check("arst_slot0", 32'(rob_if.alloc0_slot), 32'd0);
    reset = 1'b1;
    set_alloc0(1'b1, 5'd1);
    set_alloc1(1'b1, 5'd2);
    #1;
    check("post_rst_slot0", 32'(rob_if.alloc0_slot), 32'd0);
    check("post_rst_slot1", 32'(rob_if.alloc1_slot), 32'd1);
    tick();
    check("post_rst_tail", 32'(rob_if.alloc0_slot), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/riscv_corereorderbuffer.md
Name: riscv_CoreReorderBuffer

Overview:
- 2-wide reorder buffer for the IO2I core.
- Sits downstream of the decode/issue scoreboard. Entries are allocated in program order when ir0/ir1 issue, and the A and B pipeline W stages fill them out of order.
- Commits up to two entries per cycle, in order, to the register-file write ports.
- Provides the committed-pending data behind the scoreboard's byp_rob bypass select through four operand lookup ports.

Parameters:
- ENTRIES, 16: number of ROB entries; power of two, at least 4.
- IDX_W, 4: log2(ENTRIES); slot tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- alloc0_val  in  1  allocate the entry for ir0 (older).
- alloc0_dst_en  in  1  ir0 writes a register.
- alloc0_dst  in  5  ir0 destination.
- alloc1_val  in  1  allocate the entry for ir1 (younger).
- alloc1_dst_en  in  1  ir1 writes a register.
- alloc1_dst  in  5  ir1 destination.
- alloc0_slot  out  IDX_W  slot assigned to ir0 (= tail).
- alloc1_slot  out  IDX_W  slot assigned to ir1 (= tail+1 mod ENTRIES).
- alloc_rdy  out  1  at least two free entries.
- wbA_val  in  1  pipeline A writeback valid.
- wbA_slot  in  IDX_W  pipeline A writeback slot.
- wbA_data  in  32  pipeline A writeback data.
- wbB_val  in  1  pipeline B writeback valid.
- wbB_slot  in  IDX_W  pipeline B writeback slot.
- wbB_data  in  32  pipeline B writeback data.
- commit0_val  out  1  head entry retires this cycle.
- commit0_wen  out  1  head retirement writes the register file.
- commit0_dst  out  5  head destination.
- commit0_data  out  32  head result.
- commit1_val  out  1  head+1 retires this cycle.
- commit1_wen  out  1  head+1 retirement writes the register file.
- commit1_dst  out  5  head+1 destination.
- commit1_data  out  32  head+1 result.
- lkp_reg  in  20  four packed source registers {src11,src10,src01,src00}.
- lkp_hit  out  4  per-operand ROB bypass hit.
- lkp_data  out  128  per-operand bypass data, packed in the same order as lkp_reg.

Behaviour:
- Entry state: valid, done, dst_en, dst[4:0], data[31:0].
- Pointers:
  - head and tail are IDX_W bits and wrap modulo ENTRIES.
  - count is IDX_W+1 bits, range 0..ENTRIES.
- Reset (asynchronous, reset=0):
  - all valid and done bits cleared; head=tail=count=0.
  - outputs immediately: alloc_rdy=1, alloc0_slot=0, alloc1_slot=1, all commit*_val/wen=0, lkp_hit=0.
- Allocation (posedge):
  - alloc0_val writes entry[tail] with valid=1, done=0 and the dst fields.
  - alloc1_val writes entry[tail+1].
  - tail advances by the number of allocations.
  - alloc1_val without alloc0_val is illegal; the bench asserts on it.
  - allocation while alloc_rdy=0 is illegal and is ignored (no state change).
- alloc_rdy = (ENTRIES - count) >= 2. It is computed from registered count only; same-cycle commits do not free space.
- Writeback (posedge):
  - wbX_val sets entry[wbX_slot].done=1 and data=wbX_data.
  - writeback to an invalid slot is ignored.
  - wbA_slot==wbB_slot with both valid is illegal.
  - done is visible to commit and lookup the cycle after writeback (no same-cycle forwarding).
- Commit (combinational from registered state; no backpressure):
  - commit0_val = entry[head].valid & done.
  - commit1_val = commit0_val & entry[head+1].valid & done.
  - commitN_wen = commitN_val & dst_en & (dst != 0).
  - on the edge, committed entries are invalidated and head advances by the number committed.
- Count:
  - count_next = count + allocations - commits.
  - simultaneous allocate and commit on the same or wrapped slots is legal; allocation writes tail, commit frees head.
- Lookup (combinational, per operand k):
  - the matching entry is the youngest valid entry with dst_en=1 and dst==lkp_reg[k].
  - lkp_hit[k] = a match exists & match.done & (lkp_reg[k] != 0).
  - lkp_data[k] = match.data; it is 0 when lkp_hit[k]=0.
  - a younger matching entry that is not done forces hit=0, even when an older match is done.
  - entries allocated in the same cycle are not visible.
- Entries retiring this cycle are still visible to lookup until the edge.

Test Plan:
- Reset low mid-stream with 5 entries occupied → asynchronously commit0_val=0, alloc_rdy=1, alloc0_slot=0. After release, the first alloc pair gets slots 0/1.
- Alloc x5 (slot0) and x6 (slot1) together. wbB slot1=0xBEEF in cycle 2 → no commit. wbA slot0=0x1234 in cycle 3 → cycle 4: commit0 x5/0x1234 and commit1 x6/0xBEEF, both wen=1. Then count=0.
- Allocate 15 entries single-issue with no writebacks → alloc_rdy=0 at count=15. Write back the head → next cycle commit0_val=1; the following cycle alloc_rdy=1. Continue across slot 15→0 to check wrap of the tail and head pointers.
- x7 allocated in slots 2 and 3. Slot2 done 0xBB, slot3 not done → lkp x7 hit=0. Slot3 done 0xAA → hit=1, data=0xAA. lkp x0 → hit=0 always.
- Alloc with dst_en=1 dst=0, and with dst_en=0, then write back → commit0_val=1, commit0_wen=0 for both.
- Head not done, head+1 done → commit0_val=0, commit1_val=0 (in-order retirement held).
